// File: rtl/pwm_out.sv
// -----------------------------------------------------------------------------
// pwm_out
//
// PWM generator fed by a signed integer controller word (pid_in). A free-running
// period counter (cnt) runs 0..PERIOD-1 while the block is active. The duty
// value is latched from pid_in only at period boundaries. The value is clamped
// to 0..PERIOD, and the clamp direction is reported on sat_lo/sat_hi.
// sample_tick fires in the last cycle of each period. It enables the upstream
// PID stage, so the PID register and the duty latch update on the same edge.
// Dropping run lets the current period finish before the block goes idle.
//
// Ports
//   sclk        in   sole clock, rising edge
//   rst         in   synchronous active-low reset
//   run         in   1 = operate, 0 = graceful stop at the end of the period
//   pid_in      in   [Width-1:0] signed controller word, integer
//   pwm         out  PWM drive (registered)
//   sample_tick out  one-cycle strobe in the last cycle of each active period
//   duty        out  [CntW-1:0] duty in effect, in sclk cycles
//   sat_hi      out  last latched pid_in was above PERIOD
//   sat_lo      out  last latched pid_in was negative
//   dbg_state   out  [1:0] FSM state: 0 = IDLE, 1 = RUN, 2 = DRAIN
//
// Handshake: none. run is a plain level, and sample_tick is a single-cycle
// strobe that the consumer takes on the edge that ends its high cycle.
// -----------------------------------------------------------------------------
module pwm_out #(
    parameter int Width  = 18,
    parameter int CntW   = 10,
    parameter int PERIOD = 1000
) (
    input  logic                    sclk,
    input  logic                    rst,
    input  logic                    run,
    input  logic signed [Width-1:0] pid_in,
    output logic                    pwm,
    output logic                    sample_tick,
    output logic [CntW-1:0]         duty,
    output logic                    sat_hi,
    output logic                    sat_lo,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // PERIOD as a full-width signed value, so the clamp compare never
    // truncates pid_in first.
    localparam logic signed [Width-1:0] PERIOD_S = Width'(PERIOD);
    localparam logic [CntW-1:0]         PERIOD_C = CntW'(PERIOD);
    localparam logic [CntW-1:0]         LAST_C   = CntW'(PERIOD - 1);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] duty_q, duty_d;
    logic            sat_hi_q, sat_hi_d;
    logic            sat_lo_q, sat_lo_d;
    logic            pwm_q, pwm_d;
    logic            tick_q, tick_d;

    // Clamped view of pid_in, applied only when do_latch is set.
    logic [CntW-1:0] lat_duty;
    logic            lat_hi;
    logic            lat_lo;

    always_comb begin
        lat_duty = pid_in[CntW-1:0];
        lat_hi   = 1'b0;
        lat_lo   = 1'b0;
        if (pid_in < 0) begin
            lat_duty = '0;
            lat_lo   = 1'b1;
        end else if (pid_in > PERIOD_S) begin
            lat_duty = PERIOD_C;
            lat_hi   = 1'b1;
        end
    end

    logic            wrap;
    logic [CntW-1:0] cnt_inc;
    logic            do_latch;

    always_comb begin
        wrap     = (cnt_q == LAST_C);
        cnt_inc  = wrap ? '0 : cnt_q + 1'b1;
        do_latch = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        duty_d   = duty_q;
        sat_hi_d = sat_hi_q;
        sat_lo_d = sat_lo_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (run) begin
                    state_d  = S_RUN;
                    do_latch = 1'b1;
                end
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (wrap) do_latch = 1'b1;
                if (!run) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                cnt_d = cnt_inc;
                if (run) begin
                    // Re-raised run resumes without disturbing the period.
                    // A relatch happens only if this edge is also the wrap.
                    state_d = S_RUN;
                    if (wrap) do_latch = 1'b1;
                end else if (wrap) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (do_latch) begin
            duty_d   = lat_duty;
            sat_hi_d = lat_hi;
            sat_lo_d = lat_lo;
        end

        // Outputs are computed from next-state values and then registered.
        // They therefore equal a decode of the current registers and have no
        // path from pid_in to the pins.
        pwm_d  = (state_d != S_IDLE) && (cnt_d < duty_d);
        tick_d = (state_d != S_IDLE) && (cnt_d == LAST_C);
    end

    always_ff @(posedge sclk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            duty_q   <= '0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
            pwm_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            sat_hi_q <= sat_hi_d;
            sat_lo_q <= sat_lo_d;
            pwm_q    <= pwm_d;
            tick_q   <= tick_d;
        end
    end

    assign pwm         = pwm_q;
    assign sample_tick = tick_q;
    assign duty        = duty_q;
    assign sat_hi      = sat_hi_q;
    assign sat_lo      = sat_lo_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pwm_out.sv
// -----------------------------------------------------------------------------
// tb_pwm_out
//
// Bench for pwm_out with PERIOD=10, Width=18 and CntW=10. It has four parts:
//   1. A table of vectors covering reset and a steady duty=4 run.
//   2. Hand-written sequences for clamping, mid-period pid changes, the
//      graceful stop, resuming while draining, and reset in mid-period.
//   3. Randomized run/pid/rst stimulus checked every cycle against a period
//      model written with plain integers.
//   4. A one-line summary.
// -----------------------------------------------------------------------------
module tb_pwm_out;

    localparam int P  = 10;
    localparam int W  = 18;
    localparam int CW = 10;

    logic          sclk;
    logic          rst;
    logic          run;
    logic [W-1:0]  pid_in;
    logic          pwm;
    logic          sample_tick;
    logic [CW-1:0] duty;
    logic          sat_hi;
    logic          sat_lo;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    pwm_out #(.Width(W), .CntW(CW), .PERIOD(P)) dut (
        .sclk        (sclk),
        .rst         (rst),
        .run         (run),
        .pid_in      (pid_in),
        .pwm         (pwm),
        .sample_tick (sample_tick),
        .duty        (duty),
        .sat_hi      (sat_hi),
        .sat_lo      (sat_lo),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // ---------------- driver tasks ----------------
    // Advance one rising edge. Outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic rn, input int pid);
        rst    = r;
        run    = rn;
        pid_in = W'(pid);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int e_pwm, input int e_tick,
                           input int e_duty, input int e_hi, input int e_lo);
        chk({tag, ".pwm"},  int'(pwm),         e_pwm);
        chk({tag, ".tick"}, int'(sample_tick), e_tick);
        chk({tag, ".duty"}, int'(duty),        e_duty);
        chk({tag, ".hi"},   int'(sat_hi),      e_hi);
        chk({tag, ".lo"},   int'(sat_lo),      e_lo);
    endtask

    // ---------------- reference model ----------------
    // The model tracks an active flag, a stopping flag and the position
    // inside the period as plain integers.
    int m_active, m_stopping, m_pos, m_duty, m_hi, m_lo;

    task automatic m_latch(input int pid);
        if (pid < 0) begin
            m_duty = 0; m_lo = 1; m_hi = 0;
        end else if (pid > P) begin
            m_duty = P; m_lo = 0; m_hi = 1;
        end else begin
            m_duty = pid; m_lo = 0; m_hi = 0;
        end
    endtask

    task automatic m_edge(input logic r, input logic rn, input int pid);
        int at_end;
        if (!r) begin
            m_active = 0; m_stopping = 0; m_pos = 0;
            m_duty = 0; m_hi = 0; m_lo = 0;
        end else if (m_active == 0) begin
            if (rn) begin
                m_active = 1; m_stopping = 0; m_pos = 0;
                m_latch(pid);
            end
        end else begin
            at_end = (m_pos == P - 1);
            m_pos  = (m_pos + 1) % P;
            if (m_stopping == 0) begin
                if (at_end != 0) m_latch(pid);
                if (!rn) m_stopping = 1;
            end else if (at_end != 0) begin
                if (rn) begin
                    m_stopping = 0;
                    m_latch(pid);
                end else begin
                    m_active = 0; m_pos = 0;
                end
            end else if (rn) begin
                m_stopping = 0;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic r;
        logic rn;
        int   pid;
        int   e_pwm;
        int   e_tick;
        int   e_duty;
        int   e_hi;
        int   e_lo;
    } vec_t;

    vec_t tbl[22];

    int highs;
    int exp_state;

    initial begin
        set_in(1'b0, 1'b0, 0);

        // Entry 0 is reset. Entries 1..21 hold run=1 with pid=4, so the
        // period is 4 cycles high and 6 low, with a tick at position 9.
        tbl[0].r = 1'b0; tbl[0].rn = 1'b0; tbl[0].pid = 0;
        tbl[0].e_pwm = 0; tbl[0].e_tick = 0; tbl[0].e_duty = 0;
        tbl[0].e_hi = 0; tbl[0].e_lo = 0;
        for (int k = 1; k < 22; k++) begin
            tbl[k].r      = 1'b1;
            tbl[k].rn     = 1'b1;
            tbl[k].pid    = 4;
            tbl[k].e_pwm  = (((k - 1) % P) < 4) ? 1 : 0;
            tbl[k].e_tick = (((k - 1) % P) == P - 1) ? 1 : 0;
            tbl[k].e_duty = 4;
            tbl[k].e_hi   = 0;
            tbl[k].e_lo   = 0;
        end

        step();
        for (int i = 0; i < 22; i++) begin
            set_in(tbl[i].r, tbl[i].rn, tbl[i].pid);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_pwm, tbl[i].e_tick,
                    tbl[i].e_duty, tbl[i].e_hi, tbl[i].e_lo);
        end
        chk("vec.state_run", int'(dbg_state), 1);

        // ---- clamping: -5 then 25; the flags move only at the wrap edge ----
        set_in(1'b0, 1'b0, 0); step();
        chk("rst.state", int'(dbg_state), 0);
        set_in(1'b1, 1'b1, -5); step();
        chk_all("neg_start", 0, 0, 0, 0, 1);
        pid_in = W'(25);
        for (int i = 1; i < P; i++) begin
            step();
            chk_all($sformatf("neg_hold%0d", i), 0, (i == P - 1) ? 1 : 0, 0, 0, 1);
        end
        step();
        chk_all("sat_hi_wrap", 1, 0, 10, 1, 0);

        // ---- a pid change in mid-period waits for the next wrap ----
        pid_in = W'(3);
        for (int i = 1; i <= P; i++) step();
        chk_all("duty3", 1, 0, 3, 0, 0);
        highs = 0;
        for (int i = 0; i < P; i++) begin
            highs += int'(pwm);
            if (i == 5) pid_in = W'(8);
            if (i == 9) chk("duty3_held", int'(duty), 3);
            step();
        end
        chk("highs3", highs, 3);
        highs = 0;
        for (int i = 0; i < P; i++) begin
            highs += int'(pwm);
            step();
        end
        chk("highs8", highs, 8);

        // ---- run dropped at cnt=2: the period completes, then IDLE ----
        step(); step();                 // cnt=2
        run = 1'b0;
        pid_in = W'(1);
        step();                         // cnt=3
        chk("drain.state", int'(dbg_state), 2);
        for (int i = 4; i <= 9; i++) step();
        chk_all("drain_tick", 0, 1, 8, 0, 0);
        step();
        chk_all("drain_idle", 0, 0, 8, 0, 0);
        chk("drain_idle.state", int'(dbg_state), 0);
        step(); step();
        chk_all("idle_hold", 0, 0, 8, 0, 0);
        chk("idle_hold.state", int'(dbg_state), 0);

        // ---- run re-raised at cnt=6: no gap in operation ----
        set_in(1'b1, 1'b1, 8); step();  // cnt=0
        step(); step();                 // cnt=2
        run = 1'b0;
        for (int i = 3; i <= 6; i++) step();
        chk("resume.drain", int'(dbg_state), 2);
        run = 1'b1;
        pid_in = W'(2);
        step();                         // cnt=7
        chk_all("resume7", 1, 0, 8, 0, 0);
        chk("resume.state", int'(dbg_state), 1);
        step(); step();                 // cnt=9
        chk_all("resume9", 0, 1, 8, 0, 0);
        step();                         // wrap with relatch
        chk_all("resume_wrap", 1, 0, 2, 0, 0);

        // ---- reset at cnt=7 while pwm is high ----
        pid_in = W'(9);
        for (int i = 1; i <= P; i++) step();
        for (int i = 1; i <= 7; i++) step();
        chk_all("pre_rst7", 1, 0, 9, 0, 0);
        rst = 1'b0;
        step();
        chk_all("mid_rst", 0, 0, 0, 0, 0);
        chk("mid_rst.state", int'(dbg_state), 0);
        set_in(1'b1, 1'b0, 5); step(); step();
        chk_all("post_rst_idle", 0, 0, 0, 0, 0);
        chk("post_rst.state", int'(dbg_state), 0);

        // ---- randomized stimulus against the model ----
        set_in(1'b0, 1'b0, 0);
        m_edge(rst, run, 0);
        step();
        for (int c = 0; c < 4000; c++) begin
            int pid;
            logic r;
            logic rn;
            pid = int'($urandom_range(50)) - 20;
            r   = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
            rn  = ($urandom_range(7) == 0) ? ~run : run;
            set_in(r, rn, pid);
            m_edge(r, rn, pid);
            step();
            chk_all($sformatf("rnd%0d", c),
                    ((m_active != 0) && (m_pos < m_duty)) ? 1 : 0,
                    ((m_active != 0) && (m_pos == P - 1)) ? 1 : 0,
                    m_duty, m_hi, m_lo);
            exp_state = (m_active == 0) ? 0 : ((m_stopping != 0) ? 2 : 1);
            chk($sformatf("rnd%0d.state", c), int'(dbg_state), exp_state);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
